// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Core-side bus between the PC sequencer and the mips core:
//               next-PC / stop inputs, current PC, status and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  logic        enable;
  logic [31:0] updated_pc;
  logic        halt_req;
  logic [31:0] prog_ctr;
  logic        commit;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  // Core / harness side: supplies next PC and controls, observes status.
  modport master (
    output enable, updated_pc, halt_req,
    input  prog_ctr, commit, halted, fault, instr_count, cycle_count
  );

  // Sequencer side.
  modport slave (
    input  enable, updated_pc, halt_req,
    output prog_ctr, commit, halted, fault, instr_count, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter driver for the mips core. Holds prog_ctr for
//               HOLD_CYCLES enabled clocks, then commits updated_pc. Detects
//               halt request, self-loop halt idiom and misaligned targets, and
//               counts committed instructions and enabled waiting clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          HOLD_CYCLES = 3            // legal range 1..256
) (
  input  wire           clock,
  input  wire           reset,
  pc_sequencer_if.slave bus
);

  // Reload value of the hold counter; HOLD_CYCLES=256 maps to 8'hFF.
  localparam logic [7:0] c_HOLD_INIT = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [7:0]  hold_q,   hold_d;
  logic [31:0] pc_q,     pc_d;
  logic        commit_q, commit_d;
  logic        halted_q, halted_d;
  logic        fault_q,  fault_d;
  logic [31:0] instr_q,  instr_d;
  logic [31:0] cycle_q,  cycle_d;

  // State and output registers; reset takes effect immediately, mid-count too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT;
      hold_q   <= c_HOLD_INIT;
      pc_q     <= RESET_PC;
      commit_q <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      instr_q  <= 32'd0;
      cycle_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      pc_q     <= pc_d;
      commit_q <= commit_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      instr_q  <= instr_d;
      cycle_q  <= cycle_d;
    end
  end

  // Next-state logic: count down the hold, then evaluate stop conditions in
  // priority order (halt request, misalignment, self-loop) before loading.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pc_d     = pc_q;
    commit_d = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    instr_d  = instr_q;
    cycle_d  = cycle_q;

    unique case (state_q)
      S_WAIT: begin
        if (bus.enable) begin
          cycle_d = cycle_q + 32'd1;
          if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end else if (bus.halt_req) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else if (bus.updated_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else if (bus.updated_pc == pc_q) begin
            // Branch-to-self is the program's halt idiom.
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d     = bus.updated_pc;
            instr_d  = instr_q + 32'd1;
            commit_d = 1'b1;
            hold_d   = c_HOLD_INIT;
          end
        end
      end
      S_HALTED, S_FAULT: begin
        // Terminal until reset: everything holds.
      end
      default: begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.commit      = commit_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = instr_q;
  assign bus.cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer (HOLD_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .HOLD_CYCLES (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Assert reset, release it just after an edge; next edge is edge 1.
  task automatic do_reset();
    bus.enable     = 1'b0;
    bus.halt_req   = 1'b0;
    bus.updated_pc = 32'd0;
    reset          = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.prog_ctr !== 32'd0) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", bus.prog_ctr, 32'd0); end
    tests_run++; if ({bus.commit, bus.halted, bus.fault} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {bus.commit, bus.halted, bus.fault}); end
    tests_run++; if (bus.instr_count !== 32'd0 || bus.cycle_count !== 32'd0) begin tests_failed++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.instr_count, bus.cycle_count); end
  endtask

  task automatic test_stepping();
    logic [31:0] exp_pc;
    do_reset();
    exp_pc         = 32'd0;
    bus.enable     = 1'b1;
    bus.updated_pc = exp_pc + 32'd4;
    tick(); tick();
    tests_run++; if (bus.prog_ctr !== 32'd0 || bus.cycle_count !== 32'd2) begin tests_failed++; $display("FAIL step_hold got pc=%h cyc=%0d exp pc=0 cyc=2", bus.prog_ctr, bus.cycle_count); end
    tick();  // edge 3: first load
    exp_pc = 32'd4;
    tests_run++; if (bus.prog_ctr !== exp_pc || bus.commit !== 1'b1 || bus.instr_count !== 32'd1) begin tests_failed++; $display("FAIL step_load1 got pc=%h commit=%b ic=%0d exp pc=%h commit=1 ic=1", bus.prog_ctr, bus.commit, bus.instr_count, exp_pc); end
    bus.updated_pc = exp_pc + 32'd4;
    tick();  // edge 4
    tests_run++; if (bus.commit !== 1'b0 || bus.prog_ctr !== 32'd4) begin tests_failed++; $display("FAIL step_commit_drop got commit=%b pc=%h exp commit=0 pc=4", bus.commit, bus.prog_ctr); end
    tick(); tick();  // edge 6: second load
    tests_run++; if (bus.prog_ctr !== 32'd8 || bus.commit !== 1'b1) begin tests_failed++; $display("FAIL step_load2 got pc=%h commit=%b exp pc=8 commit=1", bus.prog_ctr, bus.commit); end
    tests_run++; if (bus.instr_count !== 32'd2 || bus.cycle_count !== 32'd6) begin tests_failed++; $display("FAIL step_counts got ic=%0d cyc=%0d exp ic=2 cyc=6", bus.instr_count, bus.cycle_count); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    bus.enable     = 1'b1;
    bus.updated_pc = 32'd4;
    tick();  // edge 1
    bus.enable = 1'b0;
    repeat (5) tick();  // edges 2..6
    tests_run++; if (bus.cycle_count !== 32'd1 || bus.prog_ctr !== 32'd0) begin tests_failed++; $display("FAIL freeze_hold got cyc=%0d pc=%h exp cyc=1 pc=0", bus.cycle_count, bus.prog_ctr); end
    bus.enable = 1'b1;
    tick();  // edge 7
    tests_run++; if (bus.prog_ctr !== 32'd0 || bus.cycle_count !== 32'd2) begin tests_failed++; $display("FAIL freeze_edge7 got pc=%h cyc=%0d exp pc=0 cyc=2", bus.prog_ctr, bus.cycle_count); end
    tick();  // edge 8
    tests_run++; if (bus.prog_ctr !== 32'd4 || bus.cycle_count !== 32'd3 || bus.instr_count !== 32'd1) begin tests_failed++; $display("FAIL freeze_load got pc=%h cyc=%0d ic=%0d exp pc=4 cyc=3 ic=1", bus.prog_ctr, bus.cycle_count, bus.instr_count); end
    bus.enable = 1'b0;
    tick();
    tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL freeze_commit_drop got %b exp 0", bus.commit); end
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.enable     = 1'b1;
    bus.updated_pc = 32'h0000_0006;
    repeat (3) tick();
    tests_run++; if (bus.fault !== 1'b1 || bus.halted !== 1'b0 || bus.prog_ctr !== 32'd0) begin tests_failed++; $display("FAIL misalign_detect got fault=%b halted=%b pc=%h exp 1/0/0", bus.fault, bus.halted, bus.prog_ctr); end
    bus.updated_pc = 32'h0000_0008;
    repeat (10) tick();
    tests_run++; if (bus.fault !== 1'b1 || bus.prog_ctr !== 32'd0 || bus.instr_count !== 32'd0) begin tests_failed++; $display("FAIL misalign_sticky got fault=%b pc=%h ic=%0d exp 1/0/0", bus.fault, bus.prog_ctr, bus.instr_count); end
    tests_run++; if (bus.cycle_count !== 32'd3 || bus.commit !== 1'b0) begin tests_failed++; $display("FAIL misalign_frozen got cyc=%0d commit=%b exp cyc=3 commit=0", bus.cycle_count, bus.commit); end
  endtask

  task automatic test_self_loop();
    do_reset();
    bus.enable     = 1'b1;
    bus.updated_pc = 32'd4;
    repeat (3) tick();
    bus.updated_pc = 32'd8;
    repeat (3) tick();  // PC=8 after edge 6
    tick(); tick();     // edges 7,8 still holding
    tests_run++; if (bus.halted !== 1'b0) begin tests_failed++; $display("FAIL loop_early got halted=%b exp 0", bus.halted); end
    tick();  // edge 9: evaluation sees updated_pc == prog_ctr
    tests_run++; if (bus.halted !== 1'b1 || bus.commit !== 1'b0 || bus.instr_count !== 32'd2 || bus.prog_ctr !== 32'd8) begin tests_failed++; $display("FAIL loop_halt got halted=%b commit=%b ic=%0d pc=%h exp 1/0/2/8", bus.halted, bus.commit, bus.instr_count, bus.prog_ctr); end
    bus.updated_pc = 32'd12;
    repeat (4) tick();
    tests_run++; if (bus.prog_ctr !== 32'd8 || bus.cycle_count !== 32'd9 || bus.halted !== 1'b1) begin tests_failed++; $display("FAIL loop_terminal got pc=%h cyc=%0d halted=%b exp 8/9/1", bus.prog_ctr, bus.cycle_count, bus.halted); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.enable     = 1'b1;
    bus.halt_req   = 1'b1;
    bus.updated_pc = 32'h0000_0003;
    repeat (3) tick();
    tests_run++; if (bus.halted !== 1'b1 || bus.fault !== 1'b0 || bus.prog_ctr !== 32'd0) begin tests_failed++; $display("FAIL prio_halt got halted=%b fault=%b pc=%h exp 1/0/0", bus.halted, bus.fault, bus.prog_ctr); end
    bus.halt_req = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.enable     = 1'b1;
    bus.updated_pc = 32'd4;
    repeat (4) tick();  // load at edge 3, hold_cnt=1 after edge 4
    tests_run++; if (bus.prog_ctr !== 32'd4 || bus.instr_count !== 32'd1) begin tests_failed++; $display("FAIL areset_pre got pc=%h ic=%0d exp 4/1", bus.prog_ctr, bus.instr_count); end
    #2;
    reset = 1'b1;
    #1;  // well before the next edge
    tests_run++; if (bus.prog_ctr !== 32'd0 || bus.instr_count !== 32'd0 || bus.cycle_count !== 32'd0) begin tests_failed++; $display("FAIL areset_immediate got pc=%h ic=%0d cyc=%0d exp 0/0/0", bus.prog_ctr, bus.instr_count, bus.cycle_count); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(); tick();
    tests_run++; if (bus.prog_ctr !== 32'd0) begin tests_failed++; $display("FAIL areset_hold got pc=%h exp 0", bus.prog_ctr); end
    tick();
    tests_run++; if (bus.prog_ctr !== 32'd4 || bus.commit !== 1'b1) begin tests_failed++; $display("FAIL areset_reload got pc=%h commit=%b exp 4/1", bus.prog_ctr, bus.commit); end
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stepping();
    test_enable_freeze();
    test_misaligned();
    test_self_loop();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
